fft_output: RTL and testbench

FFT_OUTPUT -- requirements
Module: fft_output

---
 rtl/fft_output.sv | 115 +++++++++++
 tb/tb_fft_output.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fft_output.sv
// Streams a finished FFT frame out of the result RAM as sample pairs (2k, 2k+1),
// through a 2-entry skid FIFO that absorbs the 1-cycle RAM latency and downstream stalls.
module fft_output #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N),
  parameter bit REVERSE_ADDR  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     start,
  input  logic [2*word_size-1:0]   rd_data1,
  input  logic [2*word_size-1:0]   rd_data2,
  output logic [address_width-1:0] addr1,
  output logic [address_width-1:0] addr2,
  output logic                     rd_en,
  output logic [2*word_size-1:0]   out_sample1,
  output logic [2*word_size-1:0]   out_sample2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     o_done
);
  localparam int DW = 2*word_size;
  localparam int KW = address_width-1;
  localparam logic [KW-1:0] K_LAST = KW'(N/2-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   rd_cnt;
  logic            inflight, inflight_last;
  logic [DW-1:0]   mem1 [2];
  logic [DW-1:0]   mem2 [2];
  logic            meml [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      occ;
  logic            xfer, room;
  logic [address_width-1:0] idx1, idx2;

  function automatic logic [address_width-1:0] bitrev(input logic [address_width-1:0] a);
    logic [address_width-1:0] r;
    for (int i = 0; i < address_width; i++) r[i] = a[address_width-1-i];
    return r;
  endfunction

  // A slot being emptied this cycle counts as free, so the pipe sustains one pair per cycle.
  assign xfer  = out_valid && out_ready;
  assign room  = (occ - {1'b0, xfer} + {1'b0, inflight}) < 2'd2;
  assign rd_en = (state == READ) && en && room;
  assign idx1  = {rd_cnt, 1'b0};
  assign idx2  = {rd_cnt, 1'b1};
  assign addr1 = !rd_en ? '0 : (REVERSE_ADDR ? bitrev(idx1) : idx1);
  assign addr2 = !rd_en ? '0 : (REVERSE_ADDR ? bitrev(idx2) : idx2);

  assign out_valid   = (occ != 2'd0);
  assign out_sample1 = mem1[rd_ptr];
  assign out_sample2 = mem2[rd_ptr];
  assign out_last    = out_valid && meml[rd_ptr];
  assign busy        = (state == READ) || (state == DRAIN);
  assign o_done      = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_cnt <= '0;
          if (start && en) state <= READ;
        end
        READ: if (rd_en) begin
          if (rd_cnt == K_LAST) state  <= DRAIN;
          else                  rd_cnt <= rd_cnt + 1'b1;
        end
        DRAIN: if (xfer && out_last) state <= DONE;
        DONE: begin
          rd_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return data is captured whether or not en is high; en only gates new reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
        meml[i] <= 1'b0;
      end
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (rd_cnt == K_LAST);
      if (inflight) begin
        mem1[wr_ptr] <= rd_data1;
        mem2[wr_ptr] <= rd_data2;
        meml[wr_ptr] <= inflight_last;
        wr_ptr       <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, xfer};
    end
  end
endmodule

// File: tb/tb_fft_output.sv
// Randomized frame readout with a queue scoreboard; a second instance covers bit-reversed addressing.
module tb_fft_output;
  localparam int N = 32, WS = 16, AW = 5, NP = N/2;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [31:0] rd_data1, rd_data2, out_sample1, out_sample2;
  logic [AW-1:0] addr1, addr2;
  logic rd_en, out_valid, out_last, busy, o_done;
  logic [31:0] r_rd_data1, r_rd_data2, r_s1, r_s2;
  logic [AW-1:0] r_addr1, r_addr2;
  logic r_rd_en, r_valid, r_last, r_busy, r_done;

  logic [31:0] ram [N];
  logic [64:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int rd_k = 0, rk = 0, issued = 0, xfers = 0, done_cnt = 0;
  int first_rd, first_v, first_x, last_x, done_cyc;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [64:0] prev_o;

  fft_output #(.N(N), .word_size(WS), .address_width(AW), .REVERSE_ADDR(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .addr1(addr1), .addr2(addr2), .rd_en(rd_en),
    .out_sample1(out_sample1), .out_sample2(out_sample2), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .o_done(o_done));

  fft_output #(.N(N), .word_size(WS), .address_width(AW), .REVERSE_ADDR(1'b1)) dut_r (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start),
    .rd_data1(r_rd_data1), .rd_data2(r_rd_data2), .addr1(r_addr1), .addr2(r_addr2), .rd_en(r_rd_en),
    .out_sample1(r_s1), .out_sample2(r_s2), .out_valid(r_valid),
    .out_ready(1'b1), .out_last(r_last), .busy(r_busy), .o_done(r_done));

  always #5 clk = ~clk;

  // RAM model with one cycle of read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data1 <= ram[addr1];     rd_data2 <= ram[addr2];
    r_rd_data1 <= ram[r_addr1]; r_rd_data2 <= ram[r_addr2];
  end

  task automatic chk(input bit ok, input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [AW-1:0] rev(input int v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Monitor: address sequence, scoreboard pops, stall stability, done pulse
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (rd_en) begin
        chk(en, "rd_en_while_en_low", 65'(rd_en), 65'(0));
        chk(rd_k < NP && addr1 == AW'(2*rd_k) && addr2 == AW'(2*rd_k+1), "addr_pair",
            {addr1, addr2}, {AW'(2*rd_k), AW'(2*rd_k+1)});
        if (first_rd < 0) first_rd = cyc;
        rd_k++; issued++;
      end
      if (r_rd_en) begin
        chk(rk < NP && r_addr1 == rev(2*rk) && r_addr2 == rev(2*rk+1), "rev_addr_pair",
            {r_addr1, r_addr2}, {rev(2*rk), rev(2*rk+1)});
        if (rk == 1)  chk(r_addr1 == 5'd8 && r_addr2 == 5'd24, "rev_pair1", {r_addr1, r_addr2}, {5'd8, 5'd24});
        if (rk == 15) chk(r_addr1 == 5'd15 && r_addr2 == 5'd31, "rev_pair15", {r_addr1, r_addr2}, {5'd15, 5'd31});
        rk++;
      end
      if (r_done) rk = 0;
      if (prev_v && !prev_r)
        chk(out_valid && {out_sample1, out_sample2, out_last} == prev_o, "stall_stable",
            {out_sample1, out_sample2, out_last}, prev_o);
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_pair", {out_sample1, out_sample2, out_last}, 65'(0));
        else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk({out_sample1, out_sample2, out_last} == e, "pair_data", {out_sample1, out_sample2, out_last}, e);
        end
        if (first_x < 0) first_x = cyc;
        last_x = cyc; xfers++;
      end
      chk(issued - xfers <= 2, "buffer_overrun", 65'(issued - xfers), 65'(2));
      if (o_done) begin
        done_cnt++; done_cyc = cyc; rd_k = 0;
        chk(!busy, "busy_in_done", 65'(busy), 65'(0));
      end
      prev_v = out_valid; prev_r = out_ready;
      prev_o = {out_sample1, out_sample2, out_last};
    end
  end

  task automatic check_outputs_zero(input string name);
    chk({addr1, addr2, rd_en, out_sample1, out_sample2, out_valid, out_last, busy, o_done} == '0,
        name, 65'({addr1, addr2, rd_en, out_valid, out_last, busy, o_done}), 65'(0));
  endtask

  // mode 0: clean; 1: ready stall after pair 2; 2: en low 3 cycles;
  // 3: random en/ready plus stray start; 4: reset at pair 7
  task automatic run_frame(input int mode);
    int guard = 0, hold = 0;
    bit used = 0;
    for (int i = 0; i < N; i++) ram[i] = (mode == 0) ? i : $urandom;
    for (int k = 0; k < NP; k++) exp_q.push_back({ram[2*k], ram[2*k+1], k == NP-1});
    first_rd = -1; first_v = -1; first_x = -1; last_x = -1; done_cyc = -1;
    issued = 0; xfers = 0; done_cnt = 0;
    en = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (done_cnt == 0 && guard < 400) begin
      case (mode)
        1: begin
          if (xfers == 3 && !used) begin hold = 5; used = 1; end
          out_ready = (hold == 0);
          if (hold > 0) hold--;
        end
        2: begin
          if (issued == 5 && !used) begin hold = 3; used = 1; end
          en = (hold == 0);
          if (hold > 0) hold--;
        end
        3: begin
          out_ready = ($urandom_range(0, 3) != 0);
          en        = ($urandom_range(0, 4) != 0);
          start     = (guard == 3);
        end
        4: if (xfers == 7) begin
          reset_n = 1'b0; #1;
          check_outputs_zero("reset_mid_frame_outputs");
          exp_q.delete();
          repeat (3) @(posedge clk);
          #1 reset_n = 1'b1; rd_k = 0; rk = 0;
          repeat (4) @(posedge clk);
          #1 chk(!busy && !out_valid && !rd_en, "idle_after_reset", {busy, out_valid, rd_en}, 65'(0));
          return;
        end
        default: ;
      endcase
      @(posedge clk); #1 guard++;
    end
    start = 1'b0; en = 1'b1; out_ready = 1'b1;
    chk(guard < 400, "frame_timeout", 65'(guard), 65'(400));
    repeat (3) @(posedge clk); #1;
    chk(done_cnt == 1, "single_done", 65'(done_cnt), 65'(1));
    chk(exp_q.size() == 0, "all_pairs_delivered", 65'(exp_q.size()), 65'(0));
    chk(xfers == NP, "pair_count", 65'(xfers), 65'(NP));
    if (mode == 0) begin
      chk(first_v - first_rd == 2, "first_valid_latency", 65'(first_v - first_rd), 65'(2));
      chk(last_x - first_x == NP-1, "no_bubbles", 65'(last_x - first_x), 65'(NP-1));
      chk(done_cyc - last_x == 1, "done_after_last", 65'(done_cyc - last_x), 65'(1));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ram[i] = i;
    #1 check_outputs_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("idle_outputs");
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(0);
    for (int f = 0; f < 6; f++) run_frame(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
